// File: rtl/uart_tx_ctrl.sv
// UART transmit frame controller.
// Accepts one data word over a valid/ready handshake and sequences start,
// data (LSB first), optional parity and stop bits. It drives the select code
// and bit values of the downstream TX bit multiplexer.
module uart_tx_ctrl #(
  parameter int DATA_BITS    = 8,
  parameter int CLKS_PER_BIT = 868,
  parameter int PARITY_EN    = 1,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic [1:0]           sel,
  output logic                 databit,
  output logic                 paritybit,
  output logic                 stopbit,
  output logic                 busy,
  output logic                 tx_done
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] CNT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(DATA_BITS - 1);
  localparam logic          STOP_LAST = 1'(STOP_BITS - 1);
  localparam logic          PAR_INV   = 1'(PARITY_ODD);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_e;

  state_e               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic                 stop_q, stop_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic                 parity_q, parity_d;
  logic                 done_q, done_d;
  logic                 bitEnd;

  assign bitEnd = (cnt_q == CNT_LAST);

  // State register and datapath registers; reset aborts any frame at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      stop_q   <= 1'b0;
      shreg_q  <= '0;
      parity_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      stop_q   <= stop_d;
      shreg_q  <= shreg_d;
      parity_q <= parity_d;
      done_q   <= done_d;
    end
  end

  // Next-state logic: baud counting, bit sequencing and the accept handshake.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    stop_d   = stop_q;
    shreg_d  = shreg_q;
    parity_d = parity_q;
    done_d   = 1'b0;

    if (state_q != IDLE) begin
      cnt_d = bitEnd ? '0 : cnt_q + CW'(1);
    end

    case (state_q)
      IDLE: begin
        if (tx_valid) begin
          state_d  = START;
          shreg_d  = tx_data;
          parity_d = (^tx_data) ^ PAR_INV;
          cnt_d    = '0;
        end
      end
      START: begin
        if (bitEnd) begin
          state_d = DATA;
          idx_d   = '0;
        end
      end
      DATA: begin
        if (bitEnd) begin
          shreg_d = shreg_q >> 1;
          if (idx_q == IDX_LAST) begin
            idx_d   = '0;
            stop_d  = 1'b0;
            state_d = (PARITY_EN != 0) ? PARITY : STOP;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      end
      PARITY: begin
        if (bitEnd) begin
          state_d = STOP;
          stop_d  = 1'b0;
        end
      end
      STOP: begin
        if (bitEnd) begin
          if (stop_q == STOP_LAST) begin
            state_d = IDLE;
            stop_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            stop_d = stop_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Mux select per state; idle and stop both present the mark level.
  always_comb begin
    sel = 2'b11;
    case (state_q)
      START:   sel = 2'b00;
      DATA:    sel = 2'b01;
      PARITY:  sel = 2'b10;
      default: sel = 2'b11;
    endcase
  end

  assign tx_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign databit   = shreg_q[0];
  assign paritybit = parity_q;
  assign stopbit   = 1'b1;
  assign tx_done   = done_q;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Directed testbench for uart_tx_ctrl.
// Three instances share clock, reset and stimulus: even parity, odd parity,
// and no parity with two stop bits, all at 4 clocks per bit.
module tb_uart_tx_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       txValid = 1'b0;
  logic [7:0] txData = 8'h00;

  logic       txReady   [3];
  logic [1:0] sel       [3];
  logic       databit   [3];
  logic       paritybit [3];
  logic       stopbit   [3];
  logic       busy      [3];
  logic       txDone    [3];

  int checks = 0;
  int errors = 0;

  logic [1:0] selLog   [3][128];
  logic       lineLog  [3][128];
  logic       readyLog [3][128];
  logic       doneLog  [3][128];
  logic       busyLog  [3][128];

  uart_tx_ctrl #(.DATA_BITS(8), .CLKS_PER_BIT(4), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) dutEven (
    .clk(clk), .rst(rst), .tx_data(txData), .tx_valid(txValid), .tx_ready(txReady[0]),
    .sel(sel[0]), .databit(databit[0]), .paritybit(paritybit[0]), .stopbit(stopbit[0]),
    .busy(busy[0]), .tx_done(txDone[0]));

  uart_tx_ctrl #(.DATA_BITS(8), .CLKS_PER_BIT(4), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) dutOdd (
    .clk(clk), .rst(rst), .tx_data(txData), .tx_valid(txValid), .tx_ready(txReady[1]),
    .sel(sel[1]), .databit(databit[1]), .paritybit(paritybit[1]), .stopbit(stopbit[1]),
    .busy(busy[1]), .tx_done(txDone[1]));

  uart_tx_ctrl #(.DATA_BITS(8), .CLKS_PER_BIT(4), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2)) dutNoPar (
    .clk(clk), .rst(rst), .tx_data(txData), .tx_valid(txValid), .tx_ready(txReady[2]),
    .sel(sel[2]), .databit(databit[2]), .paritybit(paritybit[2]), .stopbit(stopbit[2]),
    .busy(busy[2]), .tx_done(txDone[2]));

  // Free-running 100 MHz clock
  always #5 clk = ~clk;

  // Hard time limit so the run can never hang
  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [7:0] d);
    @(negedge clk);
    txValid = v;
    txData  = d;
  endtask

  // Serial line level as the downstream bit mux would produce it
  function automatic logic lineOf(input int d);
    case (sel[d])
      2'b00:   return 1'b0;
      2'b01:   return databit[d];
      2'b10:   return paritybit[d];
      default: return stopbit[d];
    endcase
  endfunction

  // Record n cycles of all three instances, sampling on the falling edge,
  // then optionally disturb the inputs after each sample.
  task automatic capture(input int n, input int noiseUntil, input int dropAt, input logic [7:0] newData);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      for (int d = 0; d < 3; d++) begin
        selLog[d][i]   = sel[d];
        lineLog[d][i]  = lineOf(d);
        readyLog[d][i] = txReady[d];
        doneLog[d][i]  = txDone[d];
        busyLog[d][i]  = busy[d];
      end
      if (i == 0) txData = newData;
      if (i < noiseUntil) begin
        txValid = i[0];
        txData  = 8'($urandom);
      end
      if (i == dropAt) txValid = 1'b0;
    end
  endtask

  function automatic logic [1:0] expSel(input int i, input bit withParity);
    if (i < 4)                    return 2'b00;
    if (i < 36)                   return 2'b01;
    if (withParity && (i < 40))   return 2'b10;
    return 2'b11;
  endfunction

  function automatic int selErrs(input int d, input int base, input bit withParity);
    int n = 0;
    for (int i = 0; i < 44; i++)
      if (selLog[d][base + i] !== expSel(i, withParity)) n++;
    return n;
  endfunction

  // Reference receiver: samples the line mid-bit, starting at the start bit
  function automatic logic [7:0] rxDecode(input int d, input int base);
    logic [7:0] b = 8'h00;
    for (int k = 0; k < 8; k++) b[k] = lineLog[d][base + 4 + 4 * k + 2];
    return b;
  endfunction

  function automatic int firstDone(input int d, input int from, input int upto);
    for (int i = from; i <= upto; i++) if (doneLog[d][i] === 1'b1) return i;
    return -1;
  endfunction

  function automatic int countOnes(input int d, input int from, input int upto, input int which);
    int n = 0;
    for (int i = from; i <= upto; i++) begin
      if (which == 0 && readyLog[d][i] === 1'b1) n++;
      if (which == 1 && doneLog[d][i] === 1'b1) n++;
      if (which == 2 && busyLog[d][i] === 1'b1) n++;
      if (which == 3 && selLog[d][i] !== 2'b11) n++;
      if (which == 4 && selLog[d][i] === 2'b10) n++;
    end
    return n;
  endfunction

  initial begin
    $display("[TB] start");

    // Reset values
    @(negedge clk);
    @(negedge clk);
    checkOutput("rst_sel",     32'(sel[0]),       32'h3);
    checkOutput("rst_ready",   32'(txReady[0]),   32'h1);
    checkOutput("rst_busy",    32'(busy[0]),      32'h0);
    checkOutput("rst_done",    32'(txDone[0]),    32'h0);
    checkOutput("rst_databit", 32'(databit[0]),   32'h0);
    checkOutput("rst_parity",  32'(paritybit[1]), 32'h0);
    checkOutput("rst_stopbit", 32'(stopbit[0]),   32'h1);
    rst = 1'b0;

    // Frame A5 with tx_data/tx_valid disturbed mid-frame
    applyStimulus(1'b1, 8'hA5);
    capture(48, 40, 40, 8'h3C);
    checkOutput("f1_sel_even",   32'(selErrs(0, 0, 1'b1)), 32'd0);
    checkOutput("f1_sel_odd",    32'(selErrs(1, 0, 1'b1)), 32'd0);
    checkOutput("f1_sel_nopar",  32'(selErrs(2, 0, 1'b0)), 32'd0);
    checkOutput("f1_rx_even",    32'(rxDecode(0, 0)), 32'hA5);
    checkOutput("f1_rx_nopar",   32'(rxDecode(2, 0)), 32'hA5);
    checkOutput("f1_startbit",   32'(lineLog[0][2]),  32'h0);
    checkOutput("f1_par_even",   32'(lineLog[0][38]), 32'h0);
    checkOutput("f1_par_odd",    32'(lineLog[1][38]), 32'h1);
    checkOutput("f1_stopbit",    32'(lineLog[0][42]), 32'h1);
    checkOutput("f1_done_at",    32'(firstDone(0, 0, 47)), 32'd44);
    checkOutput("f1_done_cnt",   32'(countOnes(0, 0, 47, 1)), 32'd1);
    checkOutput("f1_done_nopar", 32'(firstDone(2, 0, 47)), 32'd44);
    checkOutput("f1_busy_cnt",   32'(countOnes(0, 0, 47, 2)), 32'd44);
    checkOutput("f1_ready_frame",32'(countOnes(0, 0, 43, 0)), 32'd0);
    checkOutput("f1_ready_idle", 32'(readyLog[0][44]), 32'h1);
    checkOutput("f1_no_restart", 32'(countOnes(0, 44, 47, 3)), 32'd0);

    // Parity of 8'h07: even -> 1, odd -> 0
    applyStimulus(1'b1, 8'h07);
    capture(46, 0, 0, 8'h07);
    checkOutput("f2_par_even_line", 32'(lineLog[0][38]), 32'h1);
    checkOutput("f2_par_odd_line",  32'(lineLog[1][38]), 32'h0);
    checkOutput("f2_par_even_hold", 32'(paritybit[0]),   32'h1);
    checkOutput("f2_par_odd_hold",  32'(paritybit[1]),   32'h0);
    checkOutput("f2_rx_nopar",      32'(rxDecode(2, 0)), 32'h07);

    // Back-to-back 55 then AA with tx_valid held
    applyStimulus(1'b1, 8'h55);
    capture(92, 0, 45, 8'hAA);
    checkOutput("f3_done1_at",   32'(firstDone(0, 0, 91)), 32'd44);
    checkOutput("f3_start2",     32'(selLog[0][45]), 32'h0);
    checkOutput("f3_idle_sel",   32'(selLog[0][44]), 32'h3);
    checkOutput("f3_ready_cnt",  32'(countOnes(0, 0, 88, 0)), 32'd1);
    checkOutput("f3_rx1",        32'(rxDecode(0, 0)),  32'h55);
    checkOutput("f3_rx2",        32'(rxDecode(0, 45)), 32'hAA);
    checkOutput("f3_rx2_nopar",  32'(rxDecode(2, 45)), 32'hAA);
    checkOutput("f3_sel2_nopar", 32'(selErrs(2, 45, 1'b0)), 32'd0);
    checkOutput("f3_done2_at",   32'(firstDone(0, 46, 91)), 32'd89);
    checkOutput("f3_nopar_no10", 32'(countOnes(2, 0, 91, 4)), 32'd0);

    // Reset in the middle of the data bits
    applyStimulus(1'b1, 8'hFF);
    capture(10, 0, 0, 8'hFF);
    checkOutput("f4_in_data", 32'(sel[0]), 32'h1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("f4_rst_sel",    32'(sel[0]),       32'h3);
    checkOutput("f4_rst_ready",  32'(txReady[0]),   32'h1);
    checkOutput("f4_rst_busy",   32'(busy[0]),      32'h0);
    checkOutput("f4_rst_done",   32'(txDone[0]),    32'h0);
    checkOutput("f4_rst_parity", 32'(paritybit[1]), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    capture(50, 0, -1, 8'h00);
    checkOutput("f4_mark_even",  32'(countOnes(0, 0, 49, 3)), 32'd0);
    checkOutput("f4_mark_nopar", 32'(countOnes(2, 0, 49, 3)), 32'd0);
    checkOutput("f4_no_done",    32'(countOnes(0, 0, 49, 1)), 32'd0);

    // Reset and tx_valid together: nothing is accepted
    @(negedge clk);
    rst     = 1'b1;
    txValid = 1'b1;
    txData  = 8'h5A;
    @(negedge clk);
    rst     = 1'b0;
    txValid = 1'b0;
    @(negedge clk);
    checkOutput("f5_busy", 32'(busy[0]), 32'h0);
    checkOutput("f5_sel",  32'(sel[0]),  32'h3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
